// File: rtl/mrx_sig_pkg.sv
// rtl/mrx_sig_pkg.sv - shared sizing helpers and types for the mrx_sig receive correlator
package mrx_sig_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Headroom for SAMPS_PER_SYMB full-scale conjugate products, so the sum never wraps.
  function automatic int acc_width(input int sw, input int cw, input int sps);
    return sw + cw + 1 + clog2(sps);
  endfunction

  localparam int PROD_W_DEF = 33;

  typedef struct packed {
    logic signed [PROD_W_DEF-1:0] re;
    logic signed [PROD_W_DEF-1:0] im;
  } cprod_t;

endpackage

// File: rtl/mrx_sig_if.sv
// rtl/mrx_sig_if.sv - RX sample stream in, per-symbol correlation stream out
interface mrx_sig_if #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int SIN_COS_WIDTH  = 16,
  parameter int NSYMB_WIDTH    = 16,
  parameter int CNT_WIDTH      = 24,
  parameter int SAMPS_PER_SYMB = 64
);
  import mrx_sig_pkg::*;
  localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, SIN_COS_WIDTH, SAMPS_PER_SYMB);

  logic signed [SAMPLE_WIDTH-1:0]  in_i;
  logic signed [SAMPLE_WIDTH-1:0]  in_q;
  logic signed [SIN_COS_WIDTH-1:0] lo_cos;
  logic signed [SIN_COS_WIDTH-1:0] lo_sin;
  logic                            in_tvalid;
  logic                            in_tlast;
  logic                            in_tready;
  logic signed [ACC_WIDTH-1:0]     out_i;
  logic signed [ACC_WIDTH-1:0]     out_q;
  logic                            out_tvalid;
  logic                            out_tlast;
  logic                            out_tready;
  logic                            out_partial;
  logic [NSYMB_WIDTH-1:0]          symbN;
  logic [CNT_WIDTH-1:0]            sigN;

  modport slave (
    input  in_i, in_q, lo_cos, lo_sin, in_tvalid, in_tlast, out_tready,
    output in_tready, out_i, out_q, out_tvalid, out_tlast, out_partial, symbN, sigN
  );

  modport master (
    output in_i, in_q, lo_cos, lo_sin, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_i, out_q, out_tvalid, out_tlast, out_partial, symbN, sigN
  );
endinterface

// File: rtl/mrx_sig_cmult.sv
// rtl/mrx_sig_cmult.sv - registered derotation (x * conj(lo)) of one accepted sample
module mrx_cmult #(
  parameter int SW = 16,
  parameter int CW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    srst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic signed [SW-1:0]    in_i,
  input  logic signed [SW-1:0]    in_q,
  input  logic signed [CW-1:0]    lo_cos,
  input  logic signed [CW-1:0]    lo_sin,
  output logic                    out_valid,
  output logic                    out_last,
  output logic signed [SW+CW:0]   out_i,
  output logic signed [SW+CW:0]   out_q
);
  localparam int PW = SW + CW + 1;

  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic signed [PW-1:0] pi_q, pi_d, pq_q, pq_d;
  logic signed [PW-1:0] i_x, q_x, c_x, s_x;

  always_comb begin
    i_x     = PW'(in_i);
    q_x     = PW'(in_q);
    c_x     = PW'(lo_cos);
    s_x     = PW'(lo_sin);
    valid_d = valid_q;
    last_d  = last_q;
    pi_d    = pi_q;
    pq_d    = pq_q;
    if (en) begin
      valid_d = in_valid;
      last_d  = in_valid & in_last;
      if (in_valid) begin
        pi_d = i_x * c_x + q_x * s_x;
        pq_d = q_x * c_x - i_x * s_x;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
    end else if (srst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pi_q    <= '0;
      pq_q    <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      pi_q    <= pi_d;
      pq_q    <= pq_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_i     = pi_q;
  assign out_q     = pq_q;
endmodule

// File: rtl/mrx_sig.sv
// rtl/mrx_sig.sv - per-symbol integrate-and-dump of derotated RX samples with symbol/frame tagging
module mrx_sig
  import mrx_sig_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int SIN_COS_WIDTH  = 16,
  parameter int NSYMB_WIDTH    = 16,
  parameter int NSYMB          = 16,
  parameter int SAMPS_PER_SYMB = 64,
  parameter int CNT_WIDTH      = 24
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     srst,
  mrx_sig_if.slave bus
);
  localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, SIN_COS_WIDTH, SAMPS_PER_SYMB);
  localparam int SCW       = clog2(SAMPS_PER_SYMB);
  localparam int PW        = SAMPLE_WIDTH + SIN_COS_WIDTH + 1;

  logic                        en;
  logic                        s1_valid, s1_last;
  logic signed [PW-1:0]        p_i, p_q;
  logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
  logic                        at_last_samp, close, frame_end;

  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic [SCW-1:0]              samp_cnt_q, samp_cnt_d;
  logic [NSYMB_WIDTH-1:0]      symb_cnt_q, symb_cnt_d, symbN_q, symbN_d;
  logic [CNT_WIDTH-1:0]        frame_cnt_q, frame_cnt_d, sigN_q, sigN_d;
  logic                        out_tvalid_q, out_tvalid_d;
  logic                        out_tlast_q, out_tlast_d;
  logic                        out_partial_q, out_partial_d;

  // A stalled output freezes the whole pipe, so no accepted beat is ever overwritten.
  assign en            = !out_tvalid_q | bus.out_tready;
  assign bus.in_tready = en & reset_n & ~srst;

  mrx_cmult #(.SW(SAMPLE_WIDTH), .CW(SIN_COS_WIDTH)) u_cmult (
    .clk      (clk),
    .reset_n  (reset_n),
    .srst     (srst),
    .en       (en),
    .in_valid (bus.in_tvalid & bus.in_tready),
    .in_last  (bus.in_tlast),
    .in_i     (bus.in_i),
    .in_q     (bus.in_q),
    .lo_cos   (bus.lo_cos),
    .lo_sin   (bus.lo_sin),
    .out_valid(s1_valid),
    .out_last (s1_last),
    .out_i    (p_i),
    .out_q    (p_q)
  );

  always_comb begin
    sum_i         = acc_i_q + ACC_WIDTH'(p_i);
    sum_q         = acc_q_q + ACC_WIDTH'(p_q);
    at_last_samp  = (samp_cnt_q == SCW'(SAMPS_PER_SYMB - 1));
    close         = s1_valid & (at_last_samp | s1_last);
    frame_end     = (symb_cnt_q == NSYMB_WIDTH'(NSYMB - 1)) | s1_last;
    acc_i_d       = acc_i_q;
    acc_q_d       = acc_q_q;
    samp_cnt_d    = samp_cnt_q;
    symb_cnt_d    = symb_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    out_i_d       = out_i_q;
    out_q_d       = out_q_q;
    out_tvalid_d  = out_tvalid_q;
    out_tlast_d   = out_tlast_q;
    out_partial_d = out_partial_q;
    symbN_d       = symbN_q;
    sigN_d        = sigN_q;
    if (en) begin
      if (bus.out_tready) out_tvalid_d = 1'b0;
      if (close) begin
        out_i_d       = sum_i;
        out_q_d       = sum_q;
        out_tvalid_d  = 1'b1;
        out_tlast_d   = frame_end;
        out_partial_d = s1_last & ~at_last_samp;
        symbN_d       = symb_cnt_q;
        sigN_d        = frame_cnt_q;
        acc_i_d       = '0;
        acc_q_d       = '0;
        samp_cnt_d    = '0;
        if (frame_end) begin
          symb_cnt_d  = '0;
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end else begin
          symb_cnt_d  = symb_cnt_q + NSYMB_WIDTH'(1);
        end
      end else if (s1_valid) begin
        acc_i_d    = sum_i;
        acc_q_d    = sum_q;
        samp_cnt_d = samp_cnt_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_i_q <= '0; acc_q_q <= '0; samp_cnt_q <= '0; symb_cnt_q <= '0; frame_cnt_q <= '0;
      out_i_q <= '0; out_q_q <= '0; out_tvalid_q <= 1'b0; out_tlast_q <= 1'b0;
      out_partial_q <= 1'b0; symbN_q <= '0; sigN_q <= '0;
    end else if (srst) begin
      acc_i_q <= '0; acc_q_q <= '0; samp_cnt_q <= '0; symb_cnt_q <= '0; frame_cnt_q <= '0;
      out_i_q <= '0; out_q_q <= '0; out_tvalid_q <= 1'b0; out_tlast_q <= 1'b0;
      out_partial_q <= 1'b0; symbN_q <= '0; sigN_q <= '0;
    end else begin
      acc_i_q <= acc_i_d; acc_q_q <= acc_q_d; samp_cnt_q <= samp_cnt_d;
      symb_cnt_q <= symb_cnt_d; frame_cnt_q <= frame_cnt_d;
      out_i_q <= out_i_d; out_q_q <= out_q_d; out_tvalid_q <= out_tvalid_d;
      out_tlast_q <= out_tlast_d; out_partial_q <= out_partial_d;
      symbN_q <= symbN_d; sigN_q <= sigN_d;
    end
  end

  assign bus.out_i       = out_i_q;
  assign bus.out_q       = out_q_q;
  assign bus.out_tvalid  = out_tvalid_q;
  assign bus.out_tlast   = out_tlast_q;
  assign bus.out_partial = out_partial_q;
  assign bus.symbN       = symbN_q;
  assign bus.sigN        = sigN_q;
endmodule

// File: tb/tb_mrx_sig.sv
// tb/tb_mrx_sig.sv - scoreboard bench for mrx_sig with a symbol-level integrate-and-dump model
module tb_mrx_sig;
  localparam int SPS   = 4;
  localparam int NSYMB = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic srst    = 1'b0;
  always #5 clk = ~clk;

  mrx_sig_if #(.SAMPLE_WIDTH(16), .SIN_COS_WIDTH(16), .NSYMB_WIDTH(16),
               .CNT_WIDTH(24), .SAMPS_PER_SYMB(SPS)) bus ();

  mrx_sig #(.SAMPLE_WIDTH(16), .SIN_COS_WIDTH(16), .NSYMB_WIDTH(16), .NSYMB(NSYMB),
            .SAMPS_PER_SYMB(SPS), .CNT_WIDTH(24)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .srst   (srst),
    .bus    (bus)
  );

  typedef struct {
    longint ei;
    longint eq;
    longint symb;
    longint sig;
    bit     last;
    bit     partial;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ready_mode = 0;
  longint m_acc_i = 0, m_acc_q = 0;
  int     m_cnt = 0, m_symb = 0, m_sig = 0;
  longint first_i = 0, first_q = 0, last_i = 0, last_q = 0, partial_i = 0;
  bit     got_first = 0, got_partial = 0, prev_stall = 0;
  longint prev_i = 0, prev_symb = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: sum derotated samples, dump on the SPS-th sample or on tlast.
  function automatic void model_step(input longint i, input longint q, input longint c,
                                     input longint s, input bit last);
    exp_t x;
    m_acc_i += i * c + q * s;
    m_acc_q += q * c - i * s;
    m_cnt++;
    if (m_cnt == SPS || last) begin
      x.ei      = m_acc_i;
      x.eq      = m_acc_q;
      x.symb    = m_symb;
      x.sig     = m_sig;
      x.last    = (m_symb == NSYMB - 1) || last;
      x.partial = last && (m_cnt < SPS);
      sb.push_back(x);
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
      if (x.last) begin
        m_symb = 0;
        m_sig  = (m_sig + 1) % (1 << 24);
      end else begin
        m_symb++;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && !srst)
      check("in_tready_rule", bus.in_tready, (!bus.out_tvalid || bus.out_tready));
    if (bus.out_tvalid && bus.out_tready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got symbN=%0d out_i=%0d, expected no output", bus.symbN, bus.out_i);
      end else begin
        e = sb.pop_front();
        check("out_i", bus.out_i, e.ei);
        check("out_q", bus.out_q, e.eq);
        check("symbN", bus.symbN, e.symb);
        check("sigN", bus.sigN, e.sig);
        check("out_tlast", bus.out_tlast, e.last);
        check("out_partial", bus.out_partial, e.partial);
        if (!got_first) begin
          first_i = bus.out_i;
          first_q = bus.out_q;
          got_first = 1;
        end
        if (bus.out_partial) begin
          partial_i = bus.out_i;
          got_partial = 1;
        end
        last_i = bus.out_i;
        last_q = bus.out_q;
      end
    end
    if (bus.out_tvalid && !bus.out_tready) begin
      check("stall_in_tready", bus.in_tready, 0);
      if (prev_stall) begin
        check("stall_hold_i", bus.out_i, prev_i);
        check("stall_hold_symbN", bus.symbN, prev_symb);
      end
      prev_stall = 1;
      prev_i     = bus.out_i;
      prev_symb  = bus.symbN;
    end else begin
      prev_stall = 0;
    end
    if (!reset_n || srst) begin
      sb.delete();
      m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_symb = 0; m_sig = 0;
      prev_stall = 0;
    end else if (bus.in_tvalid && bus.in_tready) begin
      model_step(bus.in_i, bus.in_q, bus.lo_cos, bus.lo_sin, bus.in_tlast);
    end
  end

  initial begin
    int ph;
    ph = 0;
    bus.out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_tready = 1'b1;
        1: begin ph = (ph + 1) % 3; bus.out_tready = (ph == 0); end
        default: bus.out_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                      input logic signed [15:0] c, input logic signed [15:0] s, input bit last);
    int guard;
    bit acc;
    guard = 0;
    acc = 0;
    bus.in_i = i; bus.in_q = q; bus.lo_cos = c; bus.lo_sin = s;
    bus.in_tlast = last;
    bus.in_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no in_tready in %0d cycles, expected acceptance", guard);
    end
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
  endtask

  task automatic send_rand(input bit allow_last);
    logic signed [15:0] ri, rq, rc, rs;
    ri = 16'($urandom); rq = 16'($urandom); rc = 16'($urandom); rs = 16'($urandom);
    send(ri, rq, rc, rs, allow_last && ($urandom_range(0, 15) == 0));
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || bus.out_tvalid) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    bus.in_tvalid = 0; bus.in_tlast = 0;
    bus.in_i = 0; bus.in_q = 0; bus.lo_cos = 0; bus.lo_sin = 0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_tvalid", bus.out_tvalid, 0);
    check("rst_out_i", bus.out_i, 0);
    check("rst_out_q", bus.out_q, 0);
    check("rst_symbN", bus.symbN, 0);
    check("rst_sigN", bus.sigN, 0);
    check("rst_in_tready", bus.in_tready, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 17 symbols of a constant tone: wraps symbN and bumps sigN once
    repeat (17 * SPS) send(16384, 0, 32767, 0, 0);
    drain();
    check("tone_first_i", first_i, 64'd2147418112);
    check("tone_first_q", first_q, 0);

    repeat (SPS) send(0, 16384, 0, 32767, 0);
    drain();
    check("derot_i", last_i, 64'd2147418112);
    check("derot_q", last_q, 0);

    ready_mode = 1;
    repeat (40) send_rand(0);
    drain();

    ready_mode = 0;
    srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    repeat (5 * SPS) send(16384, 0, 32767, 0, 0);
    send(16384, 0, 32767, 0, 0);
    send(16384, 0, 32767, 0, 1);
    repeat (SPS) send(16384, 0, 32767, 0, 0);
    drain();
    check("partial_seen", got_partial, 1);
    check("partial_i", partial_i, 64'd1073709056);

    repeat (2) send_rand(0);
    srst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_out_tvalid", bus.out_tvalid, 0);
    check("srst_out_i", bus.out_i, 0);
    check("srst_sigN", bus.sigN, 0);
    srst = 1'b0;
    repeat (SPS) send(16384, 0, 32767, 0, 0);
    drain();
    check("post_srst_i", last_i, 64'd2147418112);

    repeat (2) send_rand(0);
    reset_n = 1'b0;
    #1;
    check("arst_out_tvalid", bus.out_tvalid, 0);
    check("arst_out_i", bus.out_i, 0);
    check("arst_symbN", bus.symbN, 0);
    check("arst_in_tready", bus.in_tready, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (SPS) send(16384, 0, 32767, 0, 0);
    drain();
    check("post_arst_i", last_i, 64'd2147418112);

    ready_mode = 2;
    repeat (200) send_rand(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
